// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack; one action per enabled cycle,
// priority Restart > Ret > Call > Load > increment. Registered address, 1-cycle update.
module pc_stack #(
  parameter int AW    = 7,
  parameter int DEPTH = 4,
  parameter int WRAP  = 0
) (
  input  logic                         clk_i,
  input  logic                         clr_n_i,
  input  logic                         up_i,
  input  logic                         restart_i,
  input  logic                         load_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  input  logic [AW-1:0]                load_addr_i,
  output logic [AW-1:0]                addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         stack_full_o,
  output logic                         stack_empty_o,
  output logic                         stk_err_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] MAX_ADDR = '1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);

  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;
  logic [AW-1:0] stack_q [DEPTH];

  logic [AW-1:0] next_seq;
  logic [LW-1:0] level_m1;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;
  logic          push_en;
  logic          full;
  logic          empty;

  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == '0);
  assign level_m1 = level_q - LW'(1);
  assign push_idx = level_q[IW-1:0];
  assign top_idx  = level_m1[IW-1:0];

  // Saturate or wrap at the top of the address space.
  always_comb begin
    next_seq = addr_q + AW'(1);
    if (addr_q == MAX_ADDR) begin
      next_seq = (WRAP != 0) ? '0 : MAX_ADDR;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    level_d = level_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (up_i) begin
      if (restart_i) begin
        addr_d  = '0;
        level_d = '0;
        err_d   = 1'b0;
      end else if (ret_i) begin
        if (!empty) begin
          addr_d  = stack_q[top_idx];
          level_d = level_m1;
        end else begin
          addr_d = next_seq;
          err_d  = 1'b1;
        end
      end else if (call_i) begin
        if (!full) begin
          push_en = 1'b1;
          level_d = level_q + LW'(1);
          addr_d  = load_addr_i;
        end else begin
          addr_d = next_seq;
          err_d  = 1'b1;
        end
      end else if (load_i) begin
        addr_d = load_addr_i;
      end else begin
        addr_d = next_seq;
      end
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      addr_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Entries are only meaningful below level_q, so storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      stack_q[push_idx] <= next_seq;
    end
  end

  assign addr_o        = addr_q;
  assign level_o       = level_q;
  assign stack_full_o  = full;
  assign stack_empty_o = empty;
  assign stk_err_o     = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: two instances (hold and wrap) share stimulus; a queue-based
// scoreboard compares them every cycle against an array-based reference model.
module tb_pc_stack;

  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int MAXA  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic          up = 1'b0, restart = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
  logic [AW-1:0] load_addr = '0;

  logic [AW-1:0] addr0, addr1;
  logic [LW-1:0] lvl0, lvl1;
  logic          full0, full1, empty0, empty1, err0, err1;

  pc_stack #(.AW(AW), .DEPTH(DEPTH), .WRAP(0)) dut0 (
    .clk_i(clk), .clr_n_i(clr_n), .up_i(up), .restart_i(restart), .load_i(load),
    .call_i(call), .ret_i(ret), .load_addr_i(load_addr), .addr_o(addr0),
    .level_o(lvl0), .stack_full_o(full0), .stack_empty_o(empty0), .stk_err_o(err0)
  );

  pc_stack #(.AW(AW), .DEPTH(DEPTH), .WRAP(1)) dut1 (
    .clk_i(clk), .clr_n_i(clr_n), .up_i(up), .restart_i(restart), .load_i(load),
    .call_i(call), .ret_i(ret), .load_addr_i(load_addr), .addr_o(addr1),
    .level_o(lvl1), .stack_full_o(full1), .stack_empty_o(empty1), .stk_err_o(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a0; int l0; int e0;
    int a1; int l1; int e1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: per instance an address, a plain array stack and an error flag.
  int m_addr [2];
  int m_lvl  [2];
  int m_err  [2];
  int m_stk  [2][DEPTH];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nseq(input int a, input bit wrap);
    if (a < MAXA) return a + 1;
    return wrap ? 0 : MAXA;
  endfunction

  task automatic model_apply(input int w, input bit cn, input bit u, input bit rs,
                             input bit ld, input bit cl, input bit rt, input int la);
    int ns;
    ns = nseq(m_addr[w], w == 1);
    if (!cn) begin
      m_addr[w] = 0; m_lvl[w] = 0; m_err[w] = 0;
    end else if (u) begin
      if (rs) begin
        m_addr[w] = 0; m_lvl[w] = 0; m_err[w] = 0;
      end else if (rt) begin
        if (m_lvl[w] > 0) begin
          m_lvl[w]  = m_lvl[w] - 1;
          m_addr[w] = m_stk[w][m_lvl[w]];
        end else begin
          m_addr[w] = ns; m_err[w] = 1;
        end
      end else if (cl) begin
        if (m_lvl[w] < DEPTH) begin
          m_stk[w][m_lvl[w]] = ns;
          m_lvl[w]  = m_lvl[w] + 1;
          m_addr[w] = la;
        end else begin
          m_addr[w] = ns; m_err[w] = 1;
        end
      end else if (ld) begin
        m_addr[w] = la;
      end else begin
        m_addr[w] = ns;
      end
    end
  endtask

  task automatic step(input bit cn, input bit u, input bit rs, input bit ld,
                      input bit cl, input bit rt, input int la);
    exp_t e;
    @(negedge clk);
    clr_n = cn; up = u; restart = rs; load = ld; call = cl; ret = rt;
    load_addr = AW'(la);
    for (int w = 0; w < 2; w++) model_apply(w, cn, u, rs, ld, cl, rt, la);
    e.a0 = m_addr[0]; e.l0 = m_lvl[0]; e.e0 = m_err[0];
    e.a1 = m_addr[1]; e.l1 = m_lvl[1]; e.e1 = m_err[1];
    exp_q.push_back(e);
  endtask

  task automatic inc(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle the DUTs present a new state, compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("addr_w0",  addr0,  e.a0);
        check("level_w0", lvl0,   e.l0);
        check("err_w0",   err0,   e.e0);
        check("full_w0",  full0,  int'(e.l0 == DEPTH));
        check("empty_w0", empty0, int'(e.l0 == 0));
        check("addr_w1",  addr1,  e.a1);
        check("level_w1", lvl1,   e.l1);
        check("err_w1",   err1,   e.e1);
        check("full_w1",  full1,  int'(e.l1 == DEPTH));
        check("empty_w1", empty1, int'(e.l1 == 0));
      end
    end
  end

  initial begin
    bit u, rs, ld, cl, rt, cn;
    for (int w = 0; w < 2; w++) begin
      m_addr[w] = 0; m_lvl[w] = 0; m_err[w] = 0;
    end
    clr_n = 1'b0;
    #2;
    check("reset_addr",  addr0,  0);
    check("reset_level", lvl0,   0);
    check("reset_empty", empty0, 1);
    check("reset_full",  full0,  0);
    check("reset_err",   err0,   0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Count through the whole address space: hold at 127 vs wrap to 0.
    inc(130);
    settle();
    check("inc_hold_addr", addr0, 127);
    check("inc_wrap_addr", addr1, 2);

    // Nested calls and returns.
    step(1, 1, 1, 0, 0, 0, 0);
    inc(5);
    step(1, 1, 0, 0, 1, 0, 20);
    settle();
    check("call1_addr",  addr0, 20);
    check("call1_level", lvl0,  1);
    inc(2);
    step(1, 1, 0, 0, 1, 0, 40);
    step(1, 1, 0, 0, 0, 1, 0);
    settle();
    check("ret1_addr", addr0, 23);
    step(1, 1, 0, 0, 0, 1, 0);
    settle();
    check("ret2_addr",  addr0, 6);
    check("ret2_level", lvl0,  0);

    // Overflow: four pushes fill the stack, the fifth call is dropped.
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 2);
    step(1, 1, 0, 0, 1, 0, 4);
    step(1, 1, 0, 0, 1, 0, 6);
    step(1, 1, 0, 0, 1, 0, 8);
    settle();
    check("ovf_full", full0, 1);
    inc(1);
    step(1, 1, 0, 0, 1, 0, 50);
    settle();
    check("ovf_addr",  addr0, 10);
    check("ovf_err",   err0,  1);
    check("ovf_level", lvl0,  4);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1, 0);

    // Underflow and recovery by Restart.
    step(1, 1, 1, 0, 0, 0, 0);
    inc(3);
    step(1, 1, 0, 0, 0, 1, 0);
    settle();
    check("unf_addr", addr0, 4);
    check("unf_err",  err0,  1);
    step(1, 1, 1, 0, 0, 0, 0);
    settle();
    check("restart_addr", addr0, 0);
    check("restart_err",  err0,  0);

    // Hold with Up low, then Call+Ret+Load together pops only.
    step(1, 1, 0, 0, 1, 0, 30);
    step(1, 0, 0, 0, 1, 0, 77);
    settle();
    check("hold_addr", addr0, 30);
    step(1, 1, 0, 1, 1, 1, 99);
    settle();
    check("prio_addr",  addr0, 1);
    check("prio_level", lvl0,  0);

    // Asynchronous reset between edges with three entries stacked.
    step(1, 1, 0, 0, 1, 0, 10);
    step(1, 1, 0, 0, 1, 0, 20);
    step(1, 1, 0, 0, 1, 0, 30);
    settle();
    clr_n = 1'b0;
    #1;
    check("arst_addr",  addr0,  0);
    check("arst_level", lvl0,   0);
    check("arst_empty", empty0, 1);
    check("arst_err",   err0,   0);
    for (int w = 0; w < 2; w++) model_apply(w, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cn = ($urandom_range(0, 199) != 0);
      u  = ($urandom_range(0, 99) < 85);
      rs = ($urandom_range(0, 99) < 3);
      rt = ($urandom_range(0, 99) < 22);
      cl = ($urandom_range(0, 99) < 28);
      ld = ($urandom_range(0, 99) < 15);
      step(cn, u, rs, ld, cl, rt, int'($urandom_range(0, MAXA)));
    end

    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
